// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - UART packet framing controller: sync hunt, length, payload buffer, XOR check
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 104160
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic [4:0] pkt_len,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_timeout,
    output logic       err_ovf
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_buf [MAX_LEN];
    logic [4:0]  r_pkt_len;
    logic [4:0]  r_idx;
    logic [7:0]  r_chk;
    logic [16:0] r_timer;

    logic        r_pkt_valid;
    logic        r_busy;
    logic        r_err_len;
    logic        r_err_chk;
    logic        r_err_timeout;
    logic        r_err_ovf;

    logic        w_in_frame;
    logic        w_next_in_frame;
    logic        w_len_ok;
    logic        w_last_byte;
    logic        w_timeout;
    logic        w_err_len;
    logic        w_err_chk;
    logic        w_err_ovf;

    assign w_in_frame  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_len_ok    = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
    assign w_last_byte = (r_idx == r_pkt_len - 5'd1);
    // A byte landing on the expiry cycle wins over the timeout.
    assign w_timeout   = w_in_frame && !rx_done && (r_timer == 17'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HUNT: begin
                if (rx_done && rx_data == SYNC_BYTE) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (rx_done)        w_next_state = w_len_ok ? S_PAYLOAD : S_HUNT;
                else if (w_timeout) w_next_state = S_HUNT;
            end
            S_PAYLOAD: begin
                if (rx_done && w_last_byte) w_next_state = S_CHK;
                else if (w_timeout)         w_next_state = S_HUNT;
            end
            S_CHK: begin
                if (rx_done)        w_next_state = (rx_data == r_chk) ? S_HOLD : S_HUNT;
                else if (w_timeout) w_next_state = S_HUNT;
            end
            S_HOLD: begin
                if (pkt_ready) w_next_state = S_HUNT;
            end
            default: w_next_state = S_HUNT;
        endcase
    end

    always_comb begin
        w_err_len       = (r_state == S_LEN) && rx_done && !w_len_ok;
        w_err_chk       = (r_state == S_CHK) && rx_done && (rx_data != r_chk);
        w_err_ovf       = (r_state == S_HOLD) && rx_done;
        w_next_in_frame = (w_next_state == S_LEN) || (w_next_state == S_PAYLOAD) ||
                          (w_next_state == S_CHK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_ovf     <= 1'b0;
        end else begin
            r_pkt_valid   <= (w_next_state == S_HOLD);
            r_busy        <= w_next_in_frame;
            r_err_len     <= w_err_len;
            r_err_chk     <= w_err_chk;
            r_err_timeout <= w_timeout;
            r_err_ovf     <= w_err_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_len <= 5'd0;
            r_idx     <= 5'd0;
            r_chk     <= 8'd0;
            r_timer   <= 17'd0;
        end else begin
            if (r_state == S_LEN && rx_done && w_len_ok) begin
                r_pkt_len <= rx_data[4:0];
                r_chk     <= rx_data;
                r_idx     <= 5'd0;
            end else if (r_state == S_PAYLOAD && rx_done) begin
                r_chk <= r_chk ^ rx_data;
                r_idx <= r_idx + 5'd1;
            end
            // Counts only while staying inside a frame; entry to LEN starts from zero.
            if (w_in_frame && w_next_in_frame && !rx_done) begin
                r_timer <= r_timer + 17'd1;
            end else begin
                r_timer <= 17'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && rx_done) begin
            r_buf[r_idx[3:0]] <= rx_data;
        end
    end

    assign rd_data     = r_buf[rd_addr];
    assign pkt_valid   = r_pkt_valid;
    assign pkt_len     = r_pkt_len;
    assign busy        = r_busy;
    assign err_len     = r_err_len;
    assign err_chk     = r_err_chk;
    assign err_timeout = r_err_timeout;
    assign err_ovf     = r_err_ovf;

endmodule
